muldiv_sequencer: RTL

Multi-cycle sequencer for the signed multiply and divide ALU operations. Sits beside the single-cycle ALU in the execute stage and watches the same ALUOp1/ALUOp0/funct decode the ALU control uses. Type-A mul (funct 0001) and div (funct 0010) are run iteratively, one bit per cycle. The block holds the pipeline stalled until the 2·WIDTH-bit result is ready. All other operations pass through untouched.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_datapath.sv | 102 ++++++++++
 rtl/muldiv_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Decode constants and FSM encoding shared by the multiply/divide sequencer
// and its datapath.
package muldiv_pkg;

    localparam logic [3:0] FUNCT_MUL    = 4'b0001;
    localparam logic [3:0] FUNCT_DIV    = 4'b0010;
    localparam logic [1:0] ALUOP_TYPE_A = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider with sign fix-up (divider only under MULDIV_DIV_EN).
// Latency: one operand bit per step; fix-up outputs are combinational from the registers.
// Backpressure: none; load/step are driven by the sequencer FSM.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] fix_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic             fix_dz
);

    logic [WIDTH-1:0]   hi_q, lo_q, m_q;
    logic               sa_q, sb_q;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_nxt, lo_nxt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef MULDIV_DIV_EN
    logic               div_q, dz_q;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   q_fix, r_fix;
`endif

    assign a_mag = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign b_mag = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

    // hi:lo is the product accumulator for mul and remainder:quotient for div
    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, m_q};
        if (div_q) begin
            hi_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q <= 1'b0;
            dz_q  <= 1'b0;
`endif
        end else if (load) begin
            sa_q  <= op_a[WIDTH-1];
            sb_q  <= op_b[WIDTH-1];
            hi_q  <= '0;
            lo_q  <= b_mag;
            m_q   <= a_mag;
`ifdef MULDIV_DIV_EN
            div_q <= is_div;
            dz_q  <= is_div && (op_b == '0);
            if (is_div) begin
                lo_q <= a_mag;
                m_q  <= b_mag;
                // Divide by zero skips iteration; seeding the remainder with |a|
                // lets the normal fix-up reproduce op_a.
                if (op_b == '0)
                    hi_q <= a_mag;
            end
`endif
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    assign prod     = {hi_q, lo_q};
    assign prod_fix = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;

`ifdef MULDIV_DIV_EN
    assign q_fix  = dz_q ? '1 : ((sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q);
    assign r_fix  = sa_q ? (~hi_q + 1'b1) : hi_q;
    assign fix_lo = div_q ? q_fix : prod_fix[WIDTH-1:0];
    assign fix_hi = div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_dz = dz_q;
`else
    logic unused_div;
    assign unused_div = is_div;
    assign fix_lo     = prod_fix[WIDTH-1:0];
    assign fix_hi     = prod_fix[2*WIDTH-1:WIDTH];
    assign fix_dz     = 1'b0;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Stalls the pipeline around signed iterative mul/div (div only with MULDIV_DIV_EN defined).
// Latency: done in cycle WIDTH+1 after accept (cycle 1 for div by zero).
// Backpressure: stall is high from the accept cycle until the cycle before done.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ALUOp1,
    input  logic             ALUOp0,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_nxt;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] lo_q, hi_q, fix_lo, fix_hi;
    logic             dbz_q, fix_dz;
    logic             is_type_a, is_mul_op, is_div_op, accept, busy, last_iter;

    assign is_type_a = ({ALUOp1, ALUOp0} == ALUOP_TYPE_A);
    assign is_mul_op = (funct == FUNCT_MUL);
`ifdef MULDIV_DIV_EN
    assign is_div_op = (funct == FUNCT_DIV);
`else
    assign is_div_op = 1'b0;
`endif

    assign accept    = start && is_type_a && (is_mul_op || is_div_op)
                       && (state_q == IDLE) && !flush;
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_div_op)
                        state_nxt = MUL;
                    else if (op_b == '0)
                        state_nxt = DONE;
                    else
                        state_nxt = DIV;
                end
            end
            MUL: begin
                if (flush)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                if (flush)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept)
                cnt_q <= '0;
            else if (busy)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == DONE) begin
                lo_q  <= fix_lo;
                hi_q  <= fix_hi;
                dbz_q <= fix_dz;
            end
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (busy && !flush),
        .is_div (is_div_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .fix_lo (fix_lo),
        .fix_hi (fix_hi),
        .fix_dz (fix_dz)
    );

    // Results are presented straight from the fix-up during DONE so the
    // pipeline can capture them in the same cycle it un-stalls.
    assign stall       = accept || busy;
    assign done        = (state_q == DONE);
    assign result_lo   = done ? fix_lo : lo_q;
    assign result_hi   = done ? fix_hi : hi_q;
    assign div_by_zero = done ? fix_dz : dbz_q;

endmodule
